// File: rtl/alu_pkg.sv
// Shared constants for the datapath ALU: word width and 5-bit opcode encodings.
package alu_pkg;
    localparam int WORD_SIZE = 16;

    localparam logic [4:0] NOT  = 5'h01;
    localparam logic [4:0] AND  = 5'h02;
    localparam logic [4:0] OR   = 5'h03;
    localparam logic [4:0] XOR  = 5'h04;
    localparam logic [4:0] ADD  = 5'h05;
    localparam logic [4:0] ADDI = 5'h06;
    localparam logic [4:0] SUB  = 5'h07;
    localparam logic [4:0] COMP = 5'h08;
    localparam logic [4:0] ANDI = 5'h09;
    localparam logic [4:0] SRI  = 5'h0A;
    localparam logic [4:0] SLI  = 5'h0B;
endpackage

// File: rtl/alu_if.sv
// Operand/opcode bundle between the decoder (master) and the ALU (slave).
interface alu_if import alu_pkg::*; #(parameter int W = WORD_SIZE) ();
    logic [4:0]   opcode;
    logic [W-1:0] input1;
    logic [W-1:0] input2;
    logic         alu_enable;
    logic [W-1:0] alu_out;

    modport master (output opcode, input1, input2, alu_enable, input alu_out);
    modport slave  (input opcode, input1, input2, alu_enable, output alu_out);
endinterface

// File: rtl/alu_rca.sv
// Ripple-carry adder built from a chain of full-adder bit cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_carry_adder #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        full_adder u_fa (
            .a    (a[g]),
            .b    (b[g]),
            .cin  (carry[g]),
            .sum  (sum[g]),
            .cout (carry[g+1])
        );
    end

    assign cout = carry[WIDTH];
endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU. Define ALU_SHIFT_EN to build the SRI/SLI shifter;
// without it those opcodes behave as unrecognised and alu_out holds.
module alu import alu_pkg::*; (
    input  logic  clock,
    input  logic  reset_n,
    alu_if.slave  bus
);
    logic [WORD_SIZE-1:0] a, b;
    logic [WORD_SIZE-1:0] add_b, add_sum;
    logic                 add_cin, add_cout_unused;
    logic                 is_sub;
    logic [WORD_SIZE-1:0] alu_out_d, alu_out_q;

    assign a = bus.input1;
    assign b = bus.input2;

    // SUB reuses the adder as A + ~B + 1.
    assign is_sub  = (bus.opcode == SUB);
    assign add_b   = is_sub ? ~b : b;
    assign add_cin = is_sub;

    ripple_carry_adder #(.WIDTH(WORD_SIZE)) u_add (
        .a    (a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout_unused)
    );

`ifdef ALU_SHIFT_EN
    logic                 shift_oob;
    logic [WORD_SIZE-1:0] shr, shl;

    assign shift_oob = (b >= WORD_SIZE'(WORD_SIZE));
    assign shr       = shift_oob ? '0 : (a >> b);
    assign shl       = shift_oob ? '0 : (a << b);
`endif

    always_comb begin
        alu_out_d = alu_out_q;
        if (bus.alu_enable) begin
            case (bus.opcode)
                NOT:            alu_out_d = ~a;
                AND, ANDI:      alu_out_d = a & b;
                OR:             alu_out_d = a | b;
                XOR:            alu_out_d = a ^ b;
                ADD, ADDI, SUB: alu_out_d = add_sum;
                COMP:           alu_out_d = {{(WORD_SIZE-1){1'b0}}, (a == b)};
`ifdef ALU_SHIFT_EN
                SRI:            alu_out_d = shr;
                SLI:            alu_out_d = shl;
`endif
                default:        alu_out_d = alu_out_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) alu_out_q <= '0;
        else          alu_out_q <= alu_out_d;
    end

    assign bus.alu_out = alu_out_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized ops against a reference model.
module tb_alu;
    import alu_pkg::*;

    typedef logic [WORD_SIZE-1:0] word_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    alu_if bus ();

    alu dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int    n_vec = 0;
    int    n_err = 0;
    word_t exp_q;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^WORD_SIZE; unknown ops keep prev.
    function automatic word_t ref_op(input logic [4:0] op, input word_t x, input word_t y,
                                     input word_t prev);
        longint unsigned m  = longint'(1) << WORD_SIZE;
        longint unsigned ux = x;
        longint unsigned uy = y;
        case (op)
            NOT:       return word_t'((m - 1) - ux);
            AND, ANDI: return x & y;
            OR:        return x | y;
            XOR:       return x ^ y;
            ADD, ADDI: return word_t'((ux + uy) % m);
            SUB:       return word_t'((ux + m - uy) % m);
            COMP:      return (x == y) ? word_t'(1) : word_t'(0);
`ifdef ALU_SHIFT_EN
            SRI:       return (uy >= WORD_SIZE) ? word_t'(0) : word_t'(ux / (longint'(1) << uy));
            SLI:       return (uy >= WORD_SIZE) ? word_t'(0) : word_t'((ux * (longint'(1) << uy)) % m);
`endif
            default:   return prev;
        endcase
    endfunction

    task automatic apply(input string tag, input logic [4:0] op, input word_t x, input word_t y,
                         input logic en);
        @(negedge clock);
        bus.opcode     = op;
        bus.input1     = x;
        bus.input2     = y;
        bus.alu_enable = en;
        @(posedge clock);
        #1;
        if (en) exp_q = ref_op(op, x, y, exp_q);
        check(tag, bus.alu_out, exp_q);
    endtask

    logic [4:0] ops [11] = '{NOT, AND, OR, XOR, ADD, ADDI, SUB, COMP, ANDI, SRI, SLI};

    initial begin
        reset_n        = 1'b0;
        bus.opcode     = '0;
        bus.input1     = '0;
        bus.input2     = '0;
        bus.alu_enable = 1'b0;
        exp_q          = '0;
        #1;
        check("reset", bus.alu_out, word_t'(0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        apply("dis0", ADD, 16'hAAAA, 16'h5555, 1'b0);
        apply("dis1", ADD, 16'hAAAA, 16'h5555, 1'b0);
        check("dis_zero", bus.alu_out, word_t'(0));

        apply("not",  NOT,  16'h5A5A, 16'h0000, 1'b1);
        check("not_k", bus.alu_out, 16'hA5A5);
        apply("and",  AND,  16'hAAAA, 16'h5555, 1'b1);
        apply("or",   OR,   16'hAAAA, 16'h5555, 1'b1);
        check("or_k", bus.alu_out, 16'hFFFF);
        apply("xor",  XOR,  16'hAAAA, 16'h5555, 1'b1);
        apply("andi", ANDI, 16'hAAAA, 16'h5555, 1'b1);
        check("andi_k", bus.alu_out, 16'h0000);

        apply("add",  ADD,  16'h1234, 16'h5678, 1'b1);
        check("add_k", bus.alu_out, 16'h68AC);
        apply("wrap", ADD,  16'hFFFF, 16'h0001, 1'b1);
        check("wrap_k", bus.alu_out, 16'h0000);
        apply("addi", ADDI, 16'h1234, 16'h0042, 1'b1);
        check("addi_k", bus.alu_out, 16'h1276);
        apply("sub",  SUB,  16'h5678, 16'h1234, 1'b1);
        check("sub_k", bus.alu_out, 16'h4444);
        apply("subn", SUB,  16'h1234, 16'h5678, 1'b1);
        check("subn_k", bus.alu_out, 16'hBBBC);
        for (int i = 0; i < 10; i++) begin
            apply("addi_sweep", ADD, word_t'(i), word_t'(10 - i), 1'b1);
            check("sweep_k", bus.alu_out, 16'h000A);
        end

        apply("compeq", COMP, 16'h1234, 16'h1234, 1'b1);
        check("compeq_k", bus.alu_out, 16'h0001);
        apply("compne", COMP, 16'h1234, 16'h5678, 1'b1);
        check("compne_k", bus.alu_out, 16'h0000);

        apply("sri1",  SRI, 16'h8000, 16'd1,  1'b1);
        apply("sli1",  SLI, 16'h0001, 16'd1,  1'b1);
        apply("sri8",  SRI, 16'hFFFF, 16'd8,  1'b1);
        apply("sli8",  SLI, 16'h00FF, 16'd8,  1'b1);
`ifdef ALU_SHIFT_EN
        check("sli8_k", bus.alu_out, 16'hFF00);
`endif
        apply("sli16", SLI, 16'h0001, 16'd16, 1'b1);

        apply("pre_hold", ADD, 16'h1234, 16'h5678, 1'b1);
        apply("bad_op",   5'h1F, 16'hFFFF, 16'hFFFF, 1'b1);
        check("bad_op_k", bus.alu_out, 16'h68AC);
        apply("en_off",   XOR, 16'hFFFF, 16'h0000, 1'b0);
        check("en_off_k", bus.alu_out, 16'h68AC);

        // Asynchronous reset between edges, with an enabled op pending.
        @(posedge clock);
        #3;
        bus.opcode     = ADD;
        bus.input1     = 16'h0001;
        bus.input2     = 16'h0001;
        bus.alu_enable = 1'b1;
        reset_n        = 1'b0;
        #1;
        exp_q = '0;
        check("async_rst", bus.alu_out, exp_q);
        @(posedge clock);
        #1;
        check("rst_discard", bus.alu_out, exp_q);
        @(negedge clock);
        reset_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            logic [4:0] op;
            word_t      x, y;
            logic       en;
            int unsigned r = $urandom_range(0, 14);
            op = (r < 11) ? ops[r] : 5'($urandom_range(0, 31));
            x  = word_t'($urandom);
            y  = (op == SRI || op == SLI) ? word_t'($urandom_range(0, 20)) : word_t'($urandom);
            if ((op == COMP) && ($urandom_range(0, 1) == 0)) y = x;
            en = ($urandom_range(0, 3) != 0);
            apply("rand", op, x, y, en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
